// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive FIFO between a UART receiver and its consumer. Each entry is
//   10 bits: {ferr, perr, data[7:0]}. A byte is staged on wr_tick and then
//   committed one cycle later, when the receiver's parity and frame flags
//   become valid. The read side is first-word-fall-through.
//
//   Optional build macro: UART_RX_FIFO_DROP_ERR_EN
//     Defined   : errored bytes are discarded at commit. err_drop_tick pulses
//                 for one cycle, and overflow is not set.
//     Undefined : errored bytes are stored with their flags. err_drop_tick = 0.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   wr_tick, din[7:0]     byte-received strobe and its data
//   perr_in, ferr_in      error flags, valid one cycle after wr_tick
//   rd                    pop the head entry (ignored while empty)
//   clr_ovf               clear the sticky overflow flag
//   dout, dout_perr/ferr  head entry (don't-care while empty)
//   empty, full, count    occupancy
//   overflow              sticky; set when a byte is lost to a full FIFO
//   err_drop_tick         one-cycle pulse when an errored byte is discarded
module uart_rx_fifo #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_tick,
  input  logic [7:0]        din,
  input  logic              perr_in,
  input  logic              ferr_in,
  input  logic              rd,
  input  logic              clr_ovf,
  output logic [7:0]        dout,
  output logic              dout_perr,
  output logic              dout_ferr,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              err_drop_tick
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [7:0]        stage_q, stage_d;
  logic              pend_q, pend_d;
  logic              ovf_q, ovf_d;

  logic              drop;
  logic              commit;
  logic              pop;
  logic              wr_en;
  logic              ovf_set;

  logic [9:0]        mem [DEPTH];
  logic [9:0]        head;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign count    = count_q;
  assign overflow = ovf_q;

  assign head      = mem[rd_ptr_q];
  assign dout      = head[7:0];
  assign dout_perr = head[8];
  assign dout_ferr = head[9];

  always_comb begin
    drop = 1'b0;
`ifdef UART_RX_FIFO_DROP_ERR_EN
    drop = pend_q & (perr_in | ferr_in);
`endif
    commit  = pend_q & ~drop;
    pop     = rd & ~empty;
    // When full, a simultaneous pop frees the slot the commit lands in.
    wr_en   = commit & (~full | pop);
    ovf_set = commit & full & ~pop;

    stage_d = wr_tick ? din : stage_q;
    // The entry already pending still commits at this edge even if a new
    // byte is being staged, so pending is simply the last wr_tick.
    pend_d  = wr_tick;

    wr_ptr_d = wr_en ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;

    count_d = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    ovf_d = ovf_set | (ovf_q & ~clr_ovf);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stage_q  <= '0;
      pend_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stage_q  <= stage_d;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= {ferr_in, perr_in, stage_q};
  end

`ifdef UART_RX_FIFO_DROP_ERR_EN
  logic drop_q, drop_d;

  assign drop_d        = drop;
  assign err_drop_tick = drop_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) drop_q <= 1'b0;
    else          drop_q <= drop_d;
  end
`else
  assign err_drop_tick = 1'b0;
`endif

endmodule
